fifo_unpacker: RTL and testbench

FIFO_UNPACKER -- requirements
Module: fifo_unpacker

---
 rtl/vgg_fifo_pkg.sv | 20 ++
 rtl/fifo_unpacker.sv | 128 ++++++++++++
 tb/tb_fifo_unpacker.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vgg_fifo_pkg.sv
// Shared definitions for the FIFO unpacker: FSM state encoding, default
// geometry and the channel-index width helper.
package vgg_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CHANNEL    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    POP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // A single-channel build still needs a 1-bit channel index port.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_unpacker.sv
// Pops CHANNEL-wide words from a FIFO and replays them as a ready/valid
// stream of DATA_WIDTH samples, channel 0 (LSB slice) first.
module fifo_unpacker
  import vgg_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CHANNEL    = DEF_CHANNEL
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               fifo_empty,
  input  logic [DATA_WIDTH*CHANNEL-1:0]      fifo_data,
  output logic                               fifo_rd_req,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [ch_bits(CHANNEL)-1:0]        out_ch,
  output logic                               out_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [15:0]                        word_count
);

  localparam int              CH_W    = ch_bits(CHANNEL);
  localparam logic [CH_W-1:0] CH_ZERO = {CH_W{1'b0}};
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNEL - 1);

  state_t                          state_r;
  state_t                          state_nxt_s;
  logic [DATA_WIDTH*CHANNEL-1:0]   hold_r;
  logic [CH_W-1:0]                 ch_r;
  logic [DATA_WIDTH-1:0]           out_data_r;
  logic                            out_valid_r;
  logic                            out_last_r;
  logic [15:0]                     word_count_r;

  logic                            pop_s;
  logic                            xfer_s;
  logic                            more_s;
  logic [CH_W-1:0]                 ch_inc_s;
  logic [DATA_WIDTH-1:0]           slice_s;

  // Handshake qualifiers; the pop strobe is gated by the live empty flag so
  // a FIFO that empties underneath us can never be popped.
  always_comb begin
    pop_s    = (state_r == POP) && !fifo_empty;
    xfer_s   = out_valid_r && out_ready;
    more_s   = en && !fifo_empty;
    ch_inc_s = ch_r + 1'b1;
  end

  // Slice of the held word for the channel that follows the current one.
  always_comb begin
    slice_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < CHANNEL; i++) begin
      slice_s = (ch_inc_s == CH_W'(i)) ? hold_r[i*DATA_WIDTH +: DATA_WIDTH] : slice_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (more_s) state_nxt_s = ARM;
        else        state_nxt_s = IDLE;
      end
      ARM: begin
        if (more_s) state_nxt_s = POP;
        else        state_nxt_s = IDLE;
      end
      POP: begin
        if (pop_s) state_nxt_s = DRAIN;
        else       state_nxt_s = IDLE;
      end
      DRAIN: begin
        if (xfer_s && out_last_r) begin
          if (more_s) state_nxt_s = POP;
          else        state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Holding register, channel counter, output beat and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r       <= {(DATA_WIDTH*CHANNEL){1'b0}};
      ch_r         <= CH_ZERO;
      out_data_r   <= {DATA_WIDTH{1'b0}};
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      word_count_r <= 16'd0;
    end else if (pop_s) begin
      hold_r       <= fifo_data;
      ch_r         <= CH_ZERO;
      out_data_r   <= fifo_data[DATA_WIDTH-1:0];
      out_valid_r  <= 1'b1;
      out_last_r   <= (LAST_CH == CH_ZERO);
      word_count_r <= word_count_r + 16'd1;
    end else if (xfer_s && out_last_r) begin
      ch_r        <= CH_ZERO;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (xfer_s) begin
      ch_r       <= ch_inc_s;
      out_data_r <= slice_s;
      out_last_r <= (ch_inc_s == LAST_CH);
    end
  end

  assign fifo_rd_req = pop_s;
  assign out_data    = out_data_r;
  assign out_ch      = ch_r;
  assign out_last    = out_last_r;
  assign out_valid   = out_valid_r;
  assign word_count  = word_count_r;

endmodule

// File: tb/tb_fifo_unpacker.sv
// Randomized and directed bench for fifo_unpacker against a queue-based
// FIFO/beat scoreboard.
module tb_fifo_unpacker;

  localparam int DW = 32;
  localparam int CH = 3;
  localparam int WW = DW * CH;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_empty;
  logic [WW-1:0] fifo_data;
  logic          fifo_rd_req;
  logic [DW-1:0] out_data;
  logic [1:0]    out_ch;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   word_count;

  always #5 clk = ~clk;

  fifo_unpacker #(.DATA_WIDTH(DW), .CHANNEL(CH)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_req(fifo_rd_req), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .word_count(word_count)
  );

  int checks   = 0;
  int failures = 0;

  logic [WW-1:0] fifo_q[$];
  logic [DW-1:0] exp_data_q[$];
  int            exp_ch_q[$];
  logic [DW-1:0] obs_data_q[$];
  int            obs_ch_q[$];
  logic          obs_last_q[$];
  int            rd_cyc_q[$];
  int            pops     = 0;
  int            rd_total = 0;
  int            cyc      = 0;

  logic          s_valid, s_rd, s_last;
  logic [DW-1:0] s_data;
  logic [1:0]    s_ch;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [1:0]    prev_ch;
  logic          prev_last;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? {WW{1'b0}} : fifo_q[0];
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask

  // One clock: sample and score mid-cycle, then model the FIFO pop at the edge.
  task automatic tick();
    logic [WW-1:0] w;
    #4;
    s_valid = out_valid; s_rd = fifo_rd_req; s_data = out_data;
    s_ch = out_ch; s_last = out_last;
    check_eq("valid_vs_pending", s_valid, exp_data_q.size() != 0);
    if (s_rd) begin
      check_eq("rd_while_empty", fifo_empty, 1'b0);
      check_eq("rd_mid_word", exp_data_q.size(), 0);
    end
    if (prev_stall) begin
      check_eq("stall_data", s_data, prev_data);
      check_eq("stall_ch", s_ch, prev_ch);
      check_eq("stall_last", s_last, prev_last);
    end
    if (s_valid && out_ready) begin
      check_eq("beat_pending", exp_data_q.size() != 0, 1'b1);
      if (exp_data_q.size() != 0) begin
        int ec;
        ec = exp_ch_q.pop_front();
        check_eq("beat_data", s_data, exp_data_q.pop_front());
        check_eq("beat_ch", s_ch, ec);
        check_eq("beat_last", s_last, ec == CH - 1);
      end
      obs_data_q.push_back(s_data);
      obs_ch_q.push_back(s_ch);
      obs_last_q.push_back(s_last);
    end
    check_eq("word_count", word_count, pops[15:0]);
    prev_stall = s_valid && !out_ready;
    prev_data = s_data; prev_ch = s_ch; prev_last = s_last;
    @(posedge clk); #1;
    cyc++;
    if (s_rd && fifo_q.size() != 0) begin
      w = fifo_q.pop_front();
      pops++;
      rd_total++;
      rd_cyc_q.push_back(cyc);
      for (int i = 0; i < CH; i++) begin
        exp_data_q.push_back(w[i*DW +: DW]);
        exp_ch_q.push_back(i);
      end
    end
    drive_fifo();
  endtask

  task automatic apply_reset(input int n);
    logic rd;
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      #4;
      rd = fifo_rd_req;
      @(posedge clk); #1;
      if (rd === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    drive_fifo();
    exp_data_q.delete(); exp_ch_q.delete();
    pops = 0; prev_stall = 1'b0;
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_last", out_last, 1'b0);
    check_eq("rst_ch", out_ch, 2'd0);
    check_eq("rst_data", out_data, 32'd0);
    check_eq("rst_word_count", word_count, 16'd0);
    check_eq("rst_rd_req", fifo_rd_req, 1'b0);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_data_q.size() != 0 || (en && fifo_q.size() != 0)) && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_in_budget", n < budget, 1'b1);
    repeat (3) tick();
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    tick();
    while (!s_valid && n < budget) begin
      tick();
      n++;
    end
    check_eq("wait_valid", s_valid, 1'b1);
  endtask

  task automatic clear_logs();
    obs_data_q.delete(); obs_ch_q.delete(); obs_last_q.delete(); rd_cyc_q.delete();
    rd_total = 0;
  endtask

  initial begin
    logic [WW-1:0] w;
    logic          lat_valid[4];
    logic          lat_rd[4];
    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    drive_fifo();

    // Reset held for two cycles.
    apply_reset(2);

    // Single word, streaming; check the IDLE->ARM->POP->DRAIN latency.
    clear_logs();
    out_ready = 1'b1; en = 1'b1;
    push_word({32'd3, 32'd2, 32'd1});
    for (int i = 0; i < 4; i++) begin
      tick();
      lat_valid[i] = s_valid;
      lat_rd[i]    = s_rd;
    end
    check_eq("lat_valid", {lat_valid[0], lat_valid[1], lat_valid[2], lat_valid[3]}, 4'b0001);
    check_eq("lat_rd", {lat_rd[0], lat_rd[1], lat_rd[2], lat_rd[3]}, 4'b0010);
    drain(50);
    check_eq("one_rd_pulses", rd_total, 1);
    check_eq("one_beats", obs_data_q.size(), 3);
    if (obs_data_q.size() == 3) begin
      check_eq("one_beat0", obs_data_q[0], 32'd1);
      check_eq("one_beat2", obs_data_q[2], 32'd3);
      check_eq("one_lasts", {obs_last_q[0], obs_last_q[1], obs_last_q[2]}, 3'b001);
    end
    check_eq("one_word_count", word_count, 16'd1);

    // Back-pressure for five cycles while channel 1 is presented.
    clear_logs();
    out_ready = 1'b0;
    push_word({32'd3, 32'd2, 32'd1});
    wait_valid(20);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_data", s_data, 32'd2);
      check_eq("hold_ch", s_ch, 2'd1);
      check_eq("hold_rd", s_rd, 1'b0);
    end
    out_ready = 1'b1;
    drain(50);

    // Four queued words back to back.
    apply_reset(2);
    clear_logs();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word({$urandom, $urandom, $urandom});
    drain(100);
    check_eq("b2b_beats", obs_data_q.size(), 12);
    check_eq("b2b_rd_pulses", rd_total, 4);
    if (rd_cyc_q.size() == 4) begin
      for (int i = 1; i < 4; i++) check_eq("b2b_rd_period", rd_cyc_q[i] - rd_cyc_q[i-1], 4);
    end
    check_eq("b2b_word_count", word_count, 16'd4);

    // Dropping en after the channel-0 beat finishes the word, then idles.
    clear_logs();
    push_word({32'd6, 32'd5, 32'd4});
    push_word({32'd9, 32'd8, 32'd7});
    wait_valid(20);
    en = 1'b0;
    drain(50);
    repeat (4) tick();
    check_eq("en_beats", obs_data_q.size(), 3);
    check_eq("en_rd_pulses", rd_total, 1);
    check_eq("en_fifo_left", fifo_q.size(), 1);
    check_eq("en_idle_valid", s_valid, 1'b0);
    en = 1'b1;
    drain(50);

    // Reset in the middle of a word, at channel 1.
    clear_logs();
    out_ready = 1'b0;
    push_word({32'hC, 32'hB, 32'hA});
    wait_valid(20);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check_eq("mid_ch_before_rst", s_ch, 2'd1);
    apply_reset(1);
    clear_logs();
    out_ready = 1'b1;
    push_word({32'hF, 32'hE, 32'hD});
    drain(50);
    check_eq("post_rst_beats", obs_data_q.size(), 3);
    if (obs_ch_q.size() != 0) check_eq("post_rst_first_ch", obs_ch_q[0], 0);
    if (obs_data_q.size() != 0) check_eq("post_rst_first_data", obs_data_q[0], 32'hD);

    // Random traffic, back-pressure and en toggling.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 6) begin
        w = {$urandom, $urandom, $urandom};
        push_word(w);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 9) != 0);
      tick();
    end
    en = 1'b1; out_ready = 1'b1;
    drain(300);
    check_eq("rand_fifo_drained", fifo_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout, want finish");
    $fatal(1, "timeout");
  end

endmodule
